// File: rtl/avalon_ram_responder.sv
// avalon_ram_responder: Avalon-MM RAM responder with programmable wait states, byte-lane writes and registered reads.
module avalon_ram_responder #(
  parameter int          MEM_WORDS     = 1024,
  parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
  parameter int          WAIT_CYCLES   = 2,
  parameter string       RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        protocol_error
);
  localparam int IW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [31:0] mem [MEM_WORDS] = '{default: '0};
  logic [29:0] off;
  logic [IW-1:0] idx;
  logic req, acc, valid, abort;
  assign req = read | write;
  assign off = address[31:2] - BASE_ADDR[31:2];
  assign idx = off[IW-1:0];
  // offset is unsigned, so addresses below the base wrap to a huge offset and fail the range test
  assign valid = address[1:0] == 2'b00 && address >= BASE_ADDR && off < 30'(MEM_WORDS);
  assign acc = req && !waitrequest;
  assign abort = state == S_WAIT && !req;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state == S_IDLE ? (req && WC != 0 ? S_WAIT : S_IDLE) : (!req || cnt == 0 ? S_IDLE : S_WAIT);
    cnt_n = state == S_IDLE ? (req ? WC - 4'd1 : cnt) : (req && cnt != 0 ? cnt - 4'd1 : cnt);
  end
  always_comb begin
    waitrequest = state == S_IDLE ? req && WC != 0 : cnt != 0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (abort || (acc && (!valid || (read && write)))) protocol_error <= 1'b1;
      if (acc && read && !write) readdata <= valid ? mem[idx] : 32'h0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && acc && write && valid)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
  end
endmodule

// File: tb/tb_avalon_ram_responder.sv
// tb_avalon_ram_responder: directed checks on three responders with 2, 0 and 3 wait states.
module tb_avalon_ram_responder;
  logic clk = 0;
  logic reset = 1;
  logic [31:0] address [3];
  logic read [3];
  logic write [3];
  logic [3:0] byteenable [3];
  logic [31:0] writedata [3];
  logic waitrequest [3];
  logic [31:0] readdata [3];
  logic protocol_error [3];
  int vectors = 0;
  int miscompares = 0;
  int w;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    avalon_ram_responder #(.WAIT_CYCLES(g == 0 ? 2 : g == 1 ? 0 : 3)) dut (
      .clk(clk), .reset(reset), .address(address[g]), .read(read[g]), .write(write[g]),
      .byteenable(byteenable[g]), .writedata(writedata[g]), .waitrequest(waitrequest[g]),
      .readdata(readdata[g]), .protocol_error(protocol_error[g]));
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Starts at posedge+1, holds the request until accepted, returns at posedge+1 after acceptance.
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [3:0] be, input logic [31:0] wd, output int waits);
    logic ok;
    read[d] = rd; write[d] = wr; address[d] = a; byteenable[d] = be; writedata[d] = wd;
    waits = 0;
    ok = 0;
    for (int k = 0; k < 32 && !ok; k++) begin
      @(negedge clk);
      if (waitrequest[d]) waits++; else ok = 1;
    end
    chk($sformatf("accept_d%0d", d), 32'(ok), 32'd1);
    @(posedge clk); #1;
    read[d] = 0; write[d] = 0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      address[i] = 0; read[i] = 0; write[i] = 0; byteenable[i] = 0; writedata[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_wait_d%0d", i), 32'(waitrequest[i]), 32'd0);
      chk($sformatf("rst_rdata_d%0d", i), readdata[i], 32'h0);
      chk($sformatf("rst_perr_d%0d", i), 32'(protocol_error[i]), 32'd0);
    end
    @(posedge clk); #1;
    xfer(0, 0, 1, 32'hBFC00004, 4'hF, 32'hDEADBEEF, w);
    chk("wr_waits_2", w, 2);
    xfer(0, 1, 0, 32'hBFC00004, 4'h0, 32'h0, w);
    chk("rd_waits_2", w, 2);
    chk("rd_deadbeef", readdata[0], 32'hDEADBEEF);
    chk("perr_clean_d0", 32'(protocol_error[0]), 32'd0);
    xfer(0, 0, 1, 32'hBFC00000, 4'hF, 32'h11223344, w);
    xfer(0, 0, 1, 32'hBFC00000, 4'b0101, 32'hAABBCCDD, w);
    xfer(0, 1, 0, 32'hBFC00000, 4'h0, 32'h0, w);
    chk("lane_merge", readdata[0], 32'h11BB33DD);
    xfer(1, 0, 1, 32'hBFC00008, 4'hF, 32'h0000CAFE, w);
    chk("wr_waits_0", w, 0);
    xfer(1, 1, 0, 32'hBFC00008, 4'h0, 32'h0, w);
    chk("rd_waits_0", w, 0);
    chk("rd_cafe", readdata[1], 32'h0000CAFE);
    xfer(1, 0, 1, 32'hBFC00008, 4'h0, 32'hFFFFFFFF, w);
    xfer(1, 1, 0, 32'hBFC00008, 4'h0, 32'h0, w);
    chk("noop_write", readdata[1], 32'h0000CAFE);
    chk("noop_perr", 32'(protocol_error[1]), 32'd0);
    xfer(1, 1, 1, 32'hBFC00008, 4'hF, 32'h12121212, w);
    chk("rw_rdata_held", readdata[1], 32'h0000CAFE);
    chk("rw_perr", 32'(protocol_error[1]), 32'd1);
    xfer(1, 1, 0, 32'hBFC00008, 4'h0, 32'h0, w);
    chk("rw_as_write", readdata[1], 32'h12121212);
    xfer(2, 0, 1, 32'hBFC00010, 4'hF, 32'h55AA55AA, w);
    chk("wr_waits_3", w, 3);
    xfer(2, 0, 1, 32'hBFC00014, 4'hF, 32'h0F0F0F0F, w);
    xfer(2, 1, 0, 32'hBFC00010, 4'h0, 32'h0, w);
    chk("rd_55aa", readdata[2], 32'h55AA55AA);
    address[2] = 32'hBFC00014; read[2] = 1;
    @(negedge clk);
    chk("drop_wait_hi", 32'(waitrequest[2]), 32'd1);
    @(posedge clk); #1 read[2] = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_wait_lo", 32'(waitrequest[2]), 32'd0);
    chk("drop_rdata_held", readdata[2], 32'h55AA55AA);
    chk("drop_perr", 32'(protocol_error[2]), 32'd1);
    @(posedge clk); #1;
    xfer(2, 1, 0, 32'hBFC00014, 4'h0, 32'h0, w);
    chk("post_drop_waits", w, 3);
    chk("post_drop_rdata", readdata[2], 32'h0F0F0F0F);
    xfer(0, 1, 0, 32'hBFC00002, 4'h0, 32'h0, w);
    chk("misalign_waits", w, 2);
    chk("misalign_rdata", readdata[0], 32'h0);
    chk("misalign_perr", 32'(protocol_error[0]), 32'd1);
    xfer(0, 0, 1, 32'hBFC00002, 4'hF, 32'hFFFFFFFF, w);
    xfer(0, 0, 1, 32'hBFBFFFFC, 4'hF, 32'hFFFFFFFF, w);
    xfer(0, 1, 0, 32'hBFC00000, 4'h0, 32'h0, w);
    chk("bad_writes_ignored", readdata[0], 32'h11BB33DD);
    xfer(0, 1, 0, 32'hBFC01000, 4'h0, 32'h0, w);
    chk("oor_rdata", readdata[0], 32'h0);
    xfer(0, 1, 0, 32'hBFC00FFC, 4'h0, 32'h0, w);
    chk("last_word", readdata[0], 32'h0);
    xfer(0, 1, 0, 32'hBFC00004, 4'h0, 32'h0, w);
    chk("pre_reset_rdata", readdata[0], 32'hDEADBEEF);
    address[0] = 32'hBFC00004; writedata[0] = 32'h12345678; byteenable[0] = 4'hF; write[0] = 1;
    @(negedge clk);
    chk("rst_xfer_wait", 32'(waitrequest[0]), 32'd1);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0; write[0] = 0;
    @(negedge clk);
    chk("abort_wait", 32'(waitrequest[0]), 32'd0);
    chk("abort_rdata", readdata[0], 32'h0);
    for (int i = 0; i < 3; i++) chk($sformatf("perr_cleared_d%0d", i), 32'(protocol_error[i]), 32'd0);
    @(posedge clk); #1;
    xfer(0, 1, 0, 32'hBFC00004, 4'h0, 32'h0, w);
    chk("abort_no_write", readdata[0], 32'hDEADBEEF);
    chk("abort_rd_waits", w, 2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
